// File: rtl/bf16_issue_queue_if.sv
// Op-request / result handshake bundle for bf16_issue_queue.
// master: core side (drives ops, consumes results); slave: queue side.
interface bf16_issue_queue_if #(
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_op;
   logic [31:0]      in_a;
   logic [15:0]      in_b;
   logic [31:0]      in_c;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_result;
   logic [3:0]       out_fpcsr;
   logic [TAG_W-1:0] out_tag;
   logic             out_err;

   modport master (
      output in_valid, in_op, in_a, in_b, in_c, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_fpcsr, out_tag, out_err
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_c, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_fpcsr, out_tag, out_err
   );
endinterface

// File: rtl/bf16_issue_queue.sv
// Issue/writeback controller for the BF16 conv, min/max and FMA units.
// Ports: clk, reset (async active-low), bus (op in / result out),
//   unit enables, operand pass-through, unit results and flags.
module bf16_issue_queue #(
   parameter int TAG_W    = 4,
   parameter int DEPTH    = 4,
   parameter int LAT_CONV = 1,
   parameter int LAT_MM   = 1,
   parameter int LAT_FMA  = 3
) (
   input  logic              clk,
   input  logic              reset,
   bf16_issue_queue_if.slave bus,
   output logic              conv_en,
   output logic              mm_en,
   output logic              fma_en,
   output logic [3:0]        unit_op,
   output logic [31:0]       unit_a,
   output logic [15:0]       unit_b,
   output logic [31:0]       unit_c,
   input  logic [31:0]       conv_result,
   input  logic [3:0]        conv_fpcsr,
   input  logic [15:0]       mm_result,
   input  logic [3:0]        mm_fpcsr,
   input  logic [31:0]       fma_result,
   input  logic [3:0]        fma_fpcsr
);
   localparam int M1   = (LAT_CONV > LAT_MM) ? LAT_CONV : LAT_MM;
   localparam int MAXL = (M1 > LAT_FMA) ? M1 : LAT_FMA;
   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = PW + 1;

   typedef enum logic [1:0] {C_CONV, C_MM, C_FMA, C_ILL} cls_e;

   typedef struct packed {
      logic             vld;
      cls_e             cls;
      logic [TAG_W-1:0] tag;
      logic             err;
   } pend_t;

   // slot i holds the op that captures i cycles from now
   pend_t            pend_q [MAXL];
   pend_t            pend_d [MAXL];
   logic [31:0]      res_q  [DEPTH];
   logic [3:0]       flg_q  [DEPTH];
   logic [TAG_W-1:0] tag_q  [DEPTH];
   logic             err_q  [DEPTH];
   logic [PW-1:0]    wr_q, rd_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]    infl_q, infl_d;

   cls_e        cls;
   int          lat;
   int          y;
   logic        order_ok, credit_ok;
   logic        accept, capture, pop;
   logic [31:0] cap_res;
   logic [3:0]  cap_flg;

   always_comb begin
      cls = C_ILL;
      lat = 1;
      unique case (1'b1)
         (bus.in_op < 4'd2): begin
            cls = C_CONV;
            lat = LAT_CONV;
         end
         (bus.in_op inside {4'd2, 4'd3}): begin
            cls = C_MM;
            lat = LAT_MM;
         end
         (bus.in_op inside {[4'd4:4'd10]}): begin
            cls = C_FMA;
            lat = LAT_FMA;
         end
         (bus.in_op > 4'd10): begin
            cls = C_ILL;
            lat = 1;
         end
      endcase
   end

   // youngest pending op sits in the highest valid slot
   always_comb begin
      y = 0;
      for (int i = 0; i < MAXL; i++)
         if (pend_q[i].vld) y = i;
   end

   assign order_ok  = (lat > y);
   assign credit_ok = (int'(cnt_q) + int'(infl_q)) < DEPTH;
   assign bus.in_ready = reset & credit_ok & order_ok;

   assign accept  = bus.in_valid & bus.in_ready;
   assign capture = pend_q[0].vld;
   assign pop     = bus.out_valid & bus.out_ready;

   assign conv_en = accept & (cls == C_CONV);
   assign mm_en   = accept & (cls == C_MM);
   assign fma_en  = accept & (cls == C_FMA);

   assign unit_op = bus.in_op;
   assign unit_a  = bus.in_a;
   assign unit_b  = bus.in_b;
   assign unit_c  = bus.in_c;

   always_comb begin
      cap_res = '0;
      cap_flg = '0;
      case (pend_q[0].cls)
         C_CONV: begin
            cap_res = conv_result;
            cap_flg = conv_fpcsr;
         end
         C_MM: begin
            cap_res = {16'h0, mm_result};
            cap_flg = mm_fpcsr;
         end
         C_FMA: begin
            cap_res = fma_result;
            cap_flg = fma_fpcsr;
         end
         default: ;
      endcase
   end

   // a new op lands in slot L-1 so it reaches slot 0 L cycles later
   always_comb begin
      for (int i = 0; i < MAXL - 1; i++)
         pend_d[i] = pend_q[i+1];
      pend_d[MAXL-1] = '0;
      if (accept)
         for (int i = 0; i < MAXL; i++)
            if (i == lat - 1)
               pend_d[i] = '{vld: 1'b1, cls: cls,
                             tag: bus.in_tag,
                             err: (cls == C_ILL)};
   end

   assign infl_d = infl_q + CW'(accept) - CW'(capture);
   assign cnt_d  = cnt_q + CW'(capture) - CW'(pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MAXL; i++)
            pend_q[i] <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            res_q[i] <= '0;
            flg_q[i] <= '0;
            tag_q[i] <= '0;
            err_q[i] <= 1'b0;
         end
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         infl_q <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
         infl_q <= infl_d;
         if (capture) begin
            res_q[wr_q] <= cap_res;
            flg_q[wr_q] <= cap_flg;
            tag_q[wr_q] <= pend_q[0].tag;
            err_q[wr_q] <= pend_q[0].err;
            wr_q        <= wr_q + PW'(1);
         end
         if (pop) rd_q <= rd_q + PW'(1);
      end
   end

   assign bus.out_valid  = (cnt_q != '0);
   assign bus.out_result = res_q[rd_q];
   assign bus.out_fpcsr  = flg_q[rd_q];
   assign bus.out_tag    = tag_q[rd_q];
   assign bus.out_err    = err_q[rd_q];
endmodule
